// File: rtl/timing_gen_if.sv
// Timing generator <-> controller bundle: start button, controller requests, beat/sub-beat outputs.
// step_i exists only when TIMING_STEP_EN is defined.
interface timing_gen_if #(
   parameter int CNT_W = 16
);
   logic             qd;
   logic             short_i;
   logic             long_i;
   logic             stop_i;
`ifdef TIMING_STEP_EN
   logic             step_i;
`endif
   logic             w1;
   logic             w2;
   logic             w3;
   logic             t1;
   logic             t2;
   logic             t3;
   logic             running;
   logic [CNT_W-1:0] wcnt;

   modport master (
`ifdef TIMING_STEP_EN
      input  step_i,
`endif
      input  qd, short_i, long_i, stop_i,
      output w1, w2, w3, t1, t2, t3, running, wcnt
   );

   modport slave (
`ifdef TIMING_STEP_EN
      output step_i,
`endif
      output qd, short_i, long_i, stop_i,
      input  w1, w2, w3, t1, t2, t3, running, wcnt
   );
endinterface

// File: rtl/timing_gen.sv
// Machine-cycle timing generator: W1/W2/W3 beats of BEATS clks with t1/t2/t3 sub-beats; optional TIMING_STEP_EN adds step_i.
// Start is 3 clks after qd rises; requests only act at t3; no backpressure, outputs decode registered state only.
module timing_gen #(
   parameter int BEATS = 3,
   parameter int CNT_W = 16
) (
   input  logic          clk,
   input  logic          clr,
   timing_gen_if.master  bus
);

   localparam int BW = $clog2(BEATS);
   localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
   typedef enum logic [1:0] {W_1, W_2, W_3} wsel_t;

   state_t           state, state_nxt;
   wsel_t            cur_w, w_nxt, w_after;
   logic [BW-1:0]    beat, beat_nxt;
   logic [CNT_W-1:0] wcnt, wcnt_nxt;
   logic             qd_s1, qd_s2, qd_prev;
   logic             qd_edge;
   logic             halt_req;
   logic             run;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         qd_s1   <= 1'b0;
         qd_s2   <= 1'b0;
         qd_prev <= 1'b0;
      end else begin
         qd_s1   <= bus.qd;
         qd_s2   <= qd_s1;
         qd_prev <= qd_s2;
      end
   end

   assign qd_edge = qd_s2 & ~qd_prev;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state <= IDLE;
         cur_w <= W_1;
         beat  <= '0;
         wcnt  <= '0;
      end else begin
         state <= state_nxt;
         cur_w <= w_nxt;
         beat  <= beat_nxt;
         wcnt  <= wcnt_nxt;
      end
   end

   // While halted, cur_w holds the pending W that the next start resumes at.
   always_comb begin
      state_nxt = state;
      w_nxt     = cur_w;
      beat_nxt  = beat;
      wcnt_nxt  = wcnt;
      w_after   = W_1;
      halt_req  = 1'b0;

      case (cur_w)
         W_1:     w_after = bus.short_i ? W_1 : W_2;
         W_2:     w_after = bus.long_i  ? W_3 : W_1;
         default: w_after = W_1;
      endcase

`ifdef TIMING_STEP_EN
      halt_req = bus.stop_i | (bus.step_i & (w_after == W_1));
`else
      halt_req = bus.stop_i;
`endif

      case (state)
         IDLE, HALT: begin
            if (qd_edge) begin
               state_nxt = RUN;
               beat_nxt  = '0;
            end
         end
         RUN: begin
            if (beat == LAST) begin
               beat_nxt = '0;
               wcnt_nxt = wcnt + CNT_W'(1);
               w_nxt    = w_after;
               if (halt_req) state_nxt = HALT;
            end else begin
               beat_nxt = beat + BW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            w_nxt     = W_1;
            beat_nxt  = '0;
         end
      endcase
   end

   assign run         = (state == RUN);
   assign bus.running = run;
   assign bus.w1      = run && (cur_w == W_1);
   assign bus.w2      = run && (cur_w == W_2);
   assign bus.w3      = run && (cur_w == W_3);
   assign bus.t1      = run && (beat == BW'(0));
   assign bus.t2      = run && (beat == BW'(1));
   assign bus.t3      = run && (beat == LAST);
   assign bus.wcnt    = wcnt;

endmodule

// File: tb/tb_timing_gen.sv
// Randomized and directed bench for timing_gen against a W-sequence reference model.
module tb_timing_gen;
   localparam int BEATS = 3;
   localparam int CNT_W = 16;

   logic clk = 1'b0;
   logic clr;
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   mw     = 1;
   int   mcnt   = 0;

   always #5 clk = ~clk;

   timing_gen_if #(.CNT_W(CNT_W)) bus ();
   timing_gen #(.BEATS(BEATS), .CNT_W(CNT_W)) dut (.clk(clk), .clr(clr), .bus(bus));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] obs();
      return {bus.running, bus.w1, bus.w2, bus.w3, bus.t1, bus.t2, bus.t3};
   endfunction

   // Reference: clk j of beat w, or all-zero when not running.
   function automatic logic [6:0] expv(bit run, int w, int j);
      if (!run) return 7'b0;
      return {1'b1, w == 1, w == 2, w == 3, j == 0, j == 1, j == BEATS - 1};
   endfunction

   function automatic int next_w(int w, bit s, bit l);
      if (w == 1) return s ? 1 : 2;
      if (w == 2) return l ? 3 : 1;
      return 1;
   endfunction

   task automatic set_req(bit s, bit l, bit p);
      bus.short_i = s;
      bus.long_i  = l;
      bus.stop_i  = p;
   endtask

   task automatic test_reset();
      clr = 1'b0;
      bus.qd = 1'b0;
      set_req(0, 0, 0);
`ifdef TIMING_STEP_EN
      bus.step_i = 1'b0;
`endif
      #3;
      n_cmp++;
      if (obs() !== 7'b0) begin n_fail++; $display("FAIL reset_out got=%b exp=%b", obs(), 7'b0); end
      n_cmp++;
      if (bus.wcnt !== '0) begin n_fail++; $display("FAIL reset_wcnt got=%0d exp=0", bus.wcnt); end
      tick(); tick();
      clr = 1'b1;
      mw = 1; mcnt = 0;
      tick();
   endtask

   task automatic test_basic();
      bus.qd = 1'b1;
      tick(); tick();
      n_cmp++;
      if (obs() !== 7'b0) begin n_fail++; $display("FAIL start_early got=%b exp=%b", obs(), 7'b0); end
      tick();
      bus.qd = 1'b0;
      for (int k = 0; k < 4; k++) begin
         for (int j = 0; j < BEATS; j++) begin
            n_cmp++;
            if (obs() !== expv(1, mw, j)) begin
               n_fail++; $display("FAIL basic k=%0d j=%0d got=%b exp=%b", k, j, obs(), expv(1, mw, j));
            end
            tick();
         end
         mw = next_w(mw, 0, 0); mcnt++;
      end
      n_cmp++;
      if (bus.wcnt !== CNT_W'(4)) begin n_fail++; $display("FAIL basic_wcnt got=%0d exp=4", bus.wcnt); end
   endtask

   task automatic test_long();
      // long held through W1 (ignored), W2 (-> W3), W3 (-> W1)
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < BEATS; j++) begin
            n_cmp++;
            if (obs() !== expv(1, mw, j)) begin
               n_fail++; $display("FAIL long k=%0d j=%0d got=%b exp=%b", k, j, obs(), expv(1, mw, j));
            end
            if (j == 0) set_req(0, 1, 0);
            tick();
         end
         mw = next_w(mw, 0, 1); mcnt++;
      end
      set_req(0, 0, 0);
      n_cmp++;
      if (mw != 1 || obs() !== expv(1, 1, 0)) begin
         n_fail++; $display("FAIL long_end got=%b exp=%b", obs(), expv(1, 1, 0));
      end
   endtask

   task automatic test_short();
      // short alone, then short+long together, both from W1
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < BEATS; j++) begin
            n_cmp++;
            if (obs() !== expv(1, mw, j)) begin
               n_fail++; $display("FAIL short k=%0d j=%0d got=%b exp=%b", k, j, obs(), expv(1, mw, j));
            end
            if (j == 0) set_req(1, k == 1, 0);
            tick();
         end
         mw = next_w(mw, 1, k == 1); mcnt++;
      end
      set_req(0, 0, 0);
      n_cmp++;
      if (bus.wcnt !== CNT_W'(mcnt)) begin n_fail++; $display("FAIL short_wcnt got=%0d exp=%0d", bus.wcnt, mcnt); end
   endtask

   task automatic test_stop();
      bit p;
      // W0: stop pulsed before t3 only; W1: plain; W2: stop held to t3
      for (int k = 0; k < 3; k++) begin
         p = (k == 2);
         for (int j = 0; j < BEATS; j++) begin
            n_cmp++;
            if (obs() !== expv(1, mw, j)) begin
               n_fail++; $display("FAIL stop k=%0d j=%0d got=%b exp=%b", k, j, obs(), expv(1, mw, j));
            end
            if (j == 0) set_req(0, 0, (k == 0) || p);
            if (j == 1 && k == 0) bus.stop_i = 1'b0;
            tick();
         end
         mw = next_w(mw, 0, 0); mcnt++;
      end
      set_req(0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (obs() !== 7'b0) begin n_fail++; $display("FAIL halt_hold i=%0d got=%b exp=%b", i, obs(), 7'b0); end
         tick();
      end
      n_cmp++;
      if (bus.wcnt !== CNT_W'(mcnt)) begin n_fail++; $display("FAIL halt_wcnt got=%0d exp=%0d", bus.wcnt, mcnt); end
      bus.qd = 1'b1;
      tick(); tick(); tick();
      bus.qd = 1'b0;
      // resumes at pending W2; a qd pulse while running must not disturb it
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < BEATS; j++) begin
            n_cmp++;
            if (obs() !== expv(1, mw, j)) begin
               n_fail++; $display("FAIL resume k=%0d j=%0d got=%b exp=%b", k, j, obs(), expv(1, mw, j));
            end
            if (j == 0) bus.qd = (k == 0);
            tick();
         end
         mw = next_w(mw, 0, 0); mcnt++;
      end
      bus.qd = 1'b0;
   endtask

   task automatic test_clr_mid();
      for (int k = 0; k < 2 && mw != 2; k++) begin
         for (int j = 0; j < BEATS; j++) begin
            n_cmp++;
            if (obs() !== expv(1, mw, j)) begin
               n_fail++; $display("FAIL clr_pre k=%0d j=%0d got=%b exp=%b", k, j, obs(), expv(1, mw, j));
            end
            tick();
         end
         mw = next_w(mw, 0, 0); mcnt++;
      end
      tick();
      n_cmp++;
      if (obs() !== expv(1, 2, 1)) begin n_fail++; $display("FAIL clr_w2b1 got=%b exp=%b", obs(), expv(1, 2, 1)); end
      #2 clr = 1'b0;
      #1;
      n_cmp++;
      if (obs() !== 7'b0) begin n_fail++; $display("FAIL clr_async got=%b exp=%b", obs(), 7'b0); end
      n_cmp++;
      if (bus.wcnt !== '0) begin n_fail++; $display("FAIL clr_wcnt got=%0d exp=0", bus.wcnt); end
      tick();
      clr = 1'b1;
      mw = 1; mcnt = 0;
      tick();
      bus.qd = 1'b1;
      tick(); tick(); tick();
      bus.qd = 1'b0;
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < BEATS; j++) begin
            n_cmp++;
            if (obs() !== expv(1, mw, j)) begin
               n_fail++; $display("FAIL clr_restart k=%0d j=%0d got=%b exp=%b", k, j, obs(), expv(1, mw, j));
            end
            tick();
         end
         mw = next_w(mw, 0, 0); mcnt++;
      end
   endtask

   task automatic test_random();
      bit s, l, p, st, halt;
      int nw;
      for (int k = 0; k < 40; k++) begin
         s  = $urandom_range(0, 1);
         l  = $urandom_range(0, 1);
         p  = ($urandom_range(0, 7) == 0);
         st = 1'b0;
`ifdef TIMING_STEP_EN
         st = ($urandom_range(0, 3) == 0);
`endif
         n_cmp++;
         if (bus.wcnt !== CNT_W'(mcnt)) begin n_fail++; $display("FAIL rnd_wcnt k=%0d got=%0d exp=%0d", k, bus.wcnt, mcnt); end
         for (int j = 0; j < BEATS; j++) begin
            n_cmp++;
            if (obs() !== expv(1, mw, j)) begin
               n_fail++; $display("FAIL rnd k=%0d j=%0d got=%b exp=%b", k, j, obs(), expv(1, mw, j));
            end
            if (j == 0) begin
               set_req(s, l, p);
`ifdef TIMING_STEP_EN
               bus.step_i = st;
`endif
            end
            tick();
         end
         nw   = next_w(mw, s, l);
         halt = p || (st && nw == 1);
         mw   = nw; mcnt++;
         set_req(0, 0, 0);
`ifdef TIMING_STEP_EN
         bus.step_i = 1'b0;
`endif
         if (halt) begin
            n_cmp++;
            if (obs() !== 7'b0) begin n_fail++; $display("FAIL rnd_halt k=%0d got=%b exp=%b", k, obs(), 7'b0); end
            bus.qd = 1'b1;
            tick(); tick(); tick();
            bus.qd = 1'b0;
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_long();
      test_short();
      test_stop();
      test_clr_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/timing_gen.md
Name: timing_gen

Overview:
- Machine-cycle timing generator. It is the counterpart of the hardwired controller.
- It produces the beat signals w1/w2/w3 and the t1/t2/t3 sub-beats that the controller decodes.
- It consumes the controller's short/long/stop requests to shorten, lengthen or halt the cycle sequence.
- It sits between the start pushbutton (qd) and the controller. Its t3 output drives the controller's negedge-t3 state logic.

Parameters:
- BEATS, 3: clk periods per W beat. Legal values are 3 or more.
- CNT_W, 16: width of the completed-W counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- clr  input  1  asynchronous active-low reset.
- qd  input  1  start pushbutton, asynchronous level input.
- short_i  input  1  controller request: end the instruction after W1.
- long_i  input  1  controller request: insert W3 after W2.
- stop_i  input  1  controller request: halt after the current W.
- w1  output  1  beat W1 active.
- w2  output  1  beat W2 active.
- w3  output  1  beat W3 active.
- t1  output  1  first clk of the current W.
- t2  output  1  second clk of the current W.
- t3  output  1  last clk of the current W; its falling edge marks the end of the W.
- running  output  1  high in the RUN state.
- wcnt  output  CNT_W  count of completed W beats.

Behaviour:
- Reset (clr=0, asynchronous):
  - State goes to IDLE; beat counter = 0; pending W = W1.
  - Synchronizer flops and qd_prev cleared.
  - All outputs = 0, including wcnt.
- qd synchronizer: two flops then qd_prev; edge = qd_sync & ~qd_prev.
- Start latency: qd rises before clk edge 1; w1 and t1 are high after clk edge 3.
- States: IDLE, RUN, HALT.
  - IDLE --edge--> RUN; the W entered is the pending W, at beat 0.
  - HALT --edge--> RUN; same rule, pending W at beat 0.
  - In RUN, an edge is ignored.
- Beat counter runs 0..BEATS-1 within each W.
  - t1 = RUN & beat==0.
  - t2 = RUN & beat==1.
  - t3 = RUN & beat==BEATS-1.
  - Beats 2..BEATS-2 assert no t output.
  - Exactly one of w1/w2/w3 is high in RUN; all three are low in IDLE and HALT.
- End of a W: the clk edge where t3=1. On that edge:
  - short_i/long_i/stop_i are sampled (the controller has settled them during the W).
  - wcnt increments, wrapping modulo 2^CNT_W.
  - The next W is chosen:
    - W1 with short_i=1 -> W1.
    - W1 otherwise -> W2.
    - W2 with long_i=1 -> W3.
    - W2 otherwise -> W1.
    - W3 -> W1.
  - long_i is ignored outside W2; short_i is ignored outside W1.
  - short_i and long_i both high in W1: short wins.
- stop_i sampled 1 at end of W:
  - The next W is computed as above and stored as pending; the state goes to HALT.
  - w/t outputs drop to 0 on that same edge.
- stop_i has no effect before t3. Changes mid-W are not sampled.
- clr mid-W forces IDLE immediately. After release, the next start begins at W1.
- No combinational path from short_i/long_i/stop_i to any output. All outputs are registered or decoded from state.

Optional Feature:
- Macro: TIMING_STEP_EN.
- Defined: adds input step_i (1 bit). If step_i=1 when a W ends and the next W is W1, this is treated as stop (instruction single-step). It ORs with stop_i.
- Undefined: no step_i port; halting occurs only on stop_i.

Test Plan:
- Reset then pulse qd high, short/long/stop=0:
  - w1 rises after clk edge 3.
  - Sequence is W1,W2,W1,W2..., each W 3 clk long; t3 high on the 3rd clk of each.
  - wcnt=4 after 4 Ws.
- long_i=1 held during W2:
  - Sequence W1,W2,W3,W1.
  - long_i=1 during W1 has no effect.
- short_i=1 during W1: W1 followed directly by W1.
- short_i=1 and long_i=1 during W1: next W is W1.
- stop_i=1 during W1:
  - After its t3, running=0 and w1/w2/w3=0; the state holds indefinitely.
  - qd pulse resumes at W2, beat 0.
  - qd pulse while running: no change.
- clr=0 asserted mid-W2 (beat 1):
  - All outputs 0 asynchronously; wcnt=0.
  - After release plus a qd pulse, the sequence starts at W1.
